// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle main controller: FSM states, instruction
// classes, ALU/condition codes and datapath mux selects.
// Latency: n/a (declarations only). Backpressure: n/a.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_ALU_WB   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_HALT     = 4'd9
  } ctrl_state_t;

  // Instruction class, Instr[31:30]
  localparam logic [1:0] CLASS_ALU  = 2'b00;
  localparam logic [1:0] CLASS_MEM  = 2'b01;
  localparam logic [1:0] CLASS_BR   = 2'b10;
  localparam logic [1:0] CLASS_HALT = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;

  // Branch condition codes, Instr[29:26]
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_GE = 4'h8;
  localparam logic [3:0] COND_LT = 4'h9;
  localparam logic [3:0] COND_GT = 4'hA;
  localparam logic [3:0] COND_LE = 4'hB;
  localparam logic [3:0] COND_AL = 4'hE;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  function automatic logic [1:0] instr_class(input logic [31:0] instr);
    return instr[31:30];
  endfunction

endpackage

// File: rtl/mc_main_controller_cond_eval.sv
// Branch condition evaluator: decides whether a branch is taken from the flags.
// Latency: purely combinational. Backpressure: none.
// Ports: cond[3:0] condition code, Z/N/C/V flags in; CondTrue out.
module cond_eval
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       Z,
  input  logic       N,
  input  logic       C,
  input  logic       V,
  output logic       CondTrue
);

  always_comb begin
    CondTrue = 1'b0;
    case (cond)
      COND_EQ: CondTrue = Z;
      COND_NE: CondTrue = !Z;
      COND_CS: CondTrue = C;
      COND_CC: CondTrue = !C;
      COND_MI: CondTrue = N;
      COND_PL: CondTrue = !N;
      COND_VS: CondTrue = V;
      COND_VC: CondTrue = !V;
      COND_GE: CondTrue = (N == V);
      COND_LT: CondTrue = (N != V);
      COND_GT: CondTrue = !Z && (N == V);
      COND_LE: CondTrue = Z || (N != V);
      COND_AL: CondTrue = 1'b1;
      default: CondTrue = 1'b0;  // C, D, F: never taken
    endcase
  end

endmodule

// File: rtl/mc_main_controller.sv
// Multicycle main control FSM: decodes Instr and emits one datapath control word per cycle.
// Latency: ALU 4, load 5, store 4, branch 3 cycles (+1 per memory wait); HALT reached in 2.
// Backpressure: FETCH/MEM_RD/MEM_WR hold with a constant control word until MemReady=1.
// Ports: clk, rst_n (sync, active low); Instr, Z/N/C/V, MemReady in;
//        MemReq/MemWrite/IorD, IRWrite/PCWrite/PCSrc, RegWrite/MemToReg,
//        ALUSrcA/ALUSrcB/ALUOp, Flag, Halted out.
module mc_main_controller
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instr,
  input  logic        Z,
  input  logic        N,
  input  logic        C,
  input  logic        V,
  input  logic        MemReady,
  output logic        MemReq,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        Flag,
  output logic        Halted
);

  ctrl_state_t state;
  ctrl_state_t state_nxt;
  logic        cond_true;

  // Operand/immediate fields are consumed by the datapath, not by control.
  logic unused_instr;
  assign unused_instr = ^Instr[24:0];

  cond_eval u_cond_eval (
    .cond     (Instr[29:26]),
    .Z        (Z),
    .N        (N),
    .C        (C),
    .V        (V),
    .CondTrue (cond_true)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = PCSRC_ALU;
    RegWrite  = 1'b0;
    MemToReg  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ALUOp     = ALU_ADD;
    Flag      = 1'b0;
    Halted    = 1'b0;

    case (state)
      S_FETCH: begin
        // PC + 4 is computed every fetch cycle; it only lands when memory completes.
        MemReq  = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (MemReady) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut for BRANCH.
        ALUSrcB = SRCB_BOFF;
        case (instr_class(Instr))
          CLASS_ALU: state_nxt = S_EXEC;
          CLASS_MEM: state_nxt = S_MEM_ADDR;
          CLASS_BR:  state_nxt = S_BRANCH;
          default:   state_nxt = S_HALT;
        endcase
      end
      S_EXEC: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = Instr[25] ? SRCB_IMM : SRCB_REG;
        ALUOp     = Instr[29:27];
        state_nxt = S_ALU_WB;
      end
      S_ALU_WB: begin
        // ALUOp held so the flag-write decoder sees the operation with Flag.
        RegWrite  = 1'b1;
        ALUOp     = Instr[29:27];
        Flag      = Instr[26];
        state_nxt = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = Instr[26] ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
        if (MemReady) state_nxt = S_MEM_WB;
      end
      S_MEM_WR: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) state_nxt = S_FETCH;
      end
      S_MEM_WB: begin
        RegWrite  = 1'b1;
        MemToReg  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        PCWrite   = cond_true;
        PCSrc     = PCSRC_ALUOUT;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase

    // Reset cycle: suppress every enable so an aborted access has no side effects.
    if (!rst_n) begin
      MemReq   = 1'b0;
      MemWrite = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = PCSRC_ALU;
      RegWrite = 1'b0;
      MemToReg = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = SRCB_REG;
      ALUOp    = ALU_ADD;
      Flag     = 1'b0;
      Halted   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_main_controller.sv
module tb_mc_main_controller;

  logic        clk;
  logic        rst_n;
  logic [31:0] Instr;
  logic        Z, N, C, V;
  logic        MemReady;
  logic        MemReq, MemWrite, IorD, IRWrite, PCWrite;
  logic [1:0]  PCSrc;
  logic        RegWrite, MemToReg, ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUOp;
  logic        Flag, Halted;

  mc_main_controller dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Instr    (Instr),
    .Z        (Z),
    .N        (N),
    .C        (C),
    .V        (V),
    .MemReady (MemReady),
    .MemReq   (MemReq),
    .MemWrite (MemWrite),
    .IorD     (IorD),
    .IRWrite  (IRWrite),
    .PCWrite  (PCWrite),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemToReg (MemToReg),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .Flag     (Flag),
    .Halted   (Halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       memreq;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       regwrite;
    logic       memtoreg;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic       flag;
    logic       halted;
  } cw_t;

  cw_t act;
  assign act = {MemReq, MemWrite, IorD, IRWrite, PCWrite, PCSrc, RegWrite,
                MemToReg, ALUSrcA, ALUSrcB, ALUOp, Flag, Halted};

  int checks = 0;
  int errors = 0;

  // ---------------- expected control words, straight from the operation rules
  function automatic cw_t w_fetch(input logic rdy);
    cw_t w = '0;
    w.memreq = 1'b1; w.srcb = 2'b01;
    if (rdy) begin w.irwrite = 1'b1; w.pcwrite = 1'b1; end
    return w;
  endfunction
  function automatic cw_t w_dec();
    cw_t w = '0; w.srcb = 2'b11; return w;
  endfunction
  function automatic cw_t w_exec(input logic [2:0] op, input logic imm);
    cw_t w = '0; w.srca = 1'b1; w.srcb = imm ? 2'b10 : 2'b00; w.aluop = op; return w;
  endfunction
  function automatic cw_t w_alwb(input logic [2:0] op, input logic s);
    cw_t w = '0; w.regwrite = 1'b1; w.aluop = op; w.flag = s; return w;
  endfunction
  function automatic cw_t w_madr();
    cw_t w = '0; w.srca = 1'b1; w.srcb = 2'b10; return w;
  endfunction
  function automatic cw_t w_mrd();
    cw_t w = '0; w.memreq = 1'b1; w.iord = 1'b1; return w;
  endfunction
  function automatic cw_t w_mwr();
    cw_t w = '0; w.memreq = 1'b1; w.memwrite = 1'b1; w.iord = 1'b1; return w;
  endfunction
  function automatic cw_t w_mwb();
    cw_t w = '0; w.regwrite = 1'b1; w.memtoreg = 1'b1; return w;
  endfunction
  function automatic cw_t w_br(input logic taken);
    cw_t w = '0; w.pcwrite = taken; w.pcsrc = 2'b01; return w;
  endfunction
  function automatic cw_t w_halt();
    cw_t w = '0; w.halted = 1'b1; return w;
  endfunction

  // Branch-taken rule, expressed as comparisons of flag relations.
  function automatic logic ref_taken(input logic [3:0] cc, input logic z, n, c, v);
    logic ge;
    ge = (n == v);
    case (cc)
      4'h0: return z;        4'h1: return !z;
      4'h2: return c;        4'h3: return !c;
      4'h4: return n;        4'h5: return !n;
      4'h6: return v;        4'h7: return !v;
      4'h8: return ge;       4'h9: return !ge;
      4'hA: return ge && !z; 4'hB: return !ge || z;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input cw_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %05h want %05h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply MemReady for one cycle, compare mid-cycle, advance to just after the edge.
  task automatic cyc(input logic rdy, input cw_t exp, input string nm);
    MemReady = rdy;
    @(negedge clk);
    chk(nm, exp);
    @(posedge clk);
    #1;
  endtask

  // ---------------- branch vector table
  typedef struct {
    logic [3:0] cc;
    logic       z, n, c, v;
    logic       taken;
  } br_vec_t;

  br_vec_t br_tab[17];

  // ---------------- random-run reference: per-instruction step list
  localparam int K_FIXED  = 0;  // one cycle, fixed word
  localparam int K_MEM    = 1;  // repeats word wa until MemReady, then word wb
  localparam int K_BRANCH = 2;  // word depends on live flags

  typedef struct {
    int         kind;
    cw_t        wa;
    cw_t        wb;
    logic [3:0] cc;
  } step_t;

  step_t q[$];

  task automatic push(input int k, input cw_t a, input cw_t b, input logic [3:0] cc);
    step_t s;
    s.kind = k; s.wa = a; s.wb = b; s.cc = cc;
    q.push_back(s);
  endtask

  task automatic plan_instr(input logic [31:0] ins);
    push(K_MEM, w_fetch(1'b0), w_fetch(1'b1), 4'h0);
    push(K_FIXED, w_dec(), '0, 4'h0);
    case (ins[31:30])
      2'b00: begin
        push(K_FIXED, w_exec(ins[29:27], ins[25]), '0, 4'h0);
        push(K_FIXED, w_alwb(ins[29:27], ins[26]), '0, 4'h0);
      end
      2'b01: begin
        push(K_FIXED, w_madr(), '0, 4'h0);
        if (ins[26]) begin
          push(K_MEM, w_mrd(), w_mrd(), 4'h0);
          push(K_FIXED, w_mwb(), '0, 4'h0);
        end else begin
          push(K_MEM, w_mwr(), w_mwr(), 4'h0);
        end
      end
      default: push(K_BRANCH, '0, '0, ins[29:26]);
    endcase
  endtask

  initial begin
    logic [31:0] ins;
    logic        rdy, do_rst;
    cw_t         exp;
    step_t       hd;

    br_tab[0]  = '{4'hA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};  // GT taken
    br_tab[1]  = '{4'hA, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};  // GT, Z=1
    br_tab[2]  = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};  // never
    br_tab[3]  = '{4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    br_tab[4]  = '{4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    br_tab[5]  = '{4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    br_tab[6]  = '{4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    br_tab[7]  = '{4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    br_tab[8]  = '{4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    br_tab[9]  = '{4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    br_tab[10] = '{4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    br_tab[11] = '{4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    br_tab[12] = '{4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    br_tab[13] = '{4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    br_tab[14] = '{4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    br_tab[15] = '{4'hC, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    br_tab[16] = '{4'hD, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0; Instr = '0; MemReady = 1'b1;
    Z = 1'b0; N = 1'b0; C = 1'b0; V = 1'b0;
    @(posedge clk); #1;

    // Reset held 3 cycles with MemReady high: everything quiet.
    for (int i = 0; i < 3; i++) cyc(1'b1, '0, "reset");
    rst_n = 1'b1;

    // ALU op, S=1 then S=0; second FETCH is cycle 5 of the first instruction.
    Instr = 32'h1400_0000;
    cyc(1'b1, w_fetch(1'b1), "alu_s1_fetch");
    cyc(1'b1, w_dec(), "alu_s1_decode");
    cyc(1'b1, w_exec(3'b010, 1'b0), "alu_s1_exec");
    cyc(1'b1, w_alwb(3'b010, 1'b1), "alu_s1_wb");
    Instr = 32'h1000_0000;
    cyc(1'b1, w_fetch(1'b1), "alu_s0_fetch");
    cyc(1'b1, w_dec(), "alu_s0_decode");
    cyc(1'b1, w_exec(3'b010, 1'b0), "alu_s0_exec");
    cyc(1'b1, w_alwb(3'b010, 1'b0), "alu_s0_wb");

    // Load with two wait states in MEM_RD: 7 cycles.
    Instr = 32'h4400_0000;
    cyc(1'b1, w_fetch(1'b1), "ld_fetch");
    cyc(1'b1, w_dec(), "ld_decode");
    cyc(1'b1, w_madr(), "ld_addr");
    cyc(1'b0, w_mrd(), "ld_rd_wait1");
    cyc(1'b0, w_mrd(), "ld_rd_wait2");
    cyc(1'b1, w_mrd(), "ld_rd_done");
    cyc(1'b1, w_mwb(), "ld_wb");

    // Branch vectors.
    for (int i = 0; i < 17; i++) begin
      Instr = {2'b10, br_tab[i].cc, 26'd0};
      {Z, N, C, V} = {br_tab[i].z, br_tab[i].n, br_tab[i].c, br_tab[i].v};
      cyc(1'b1, w_fetch(1'b1), "br_fetch");
      cyc(1'b1, w_dec(), "br_decode");
      cyc(1'b1, w_br(br_tab[i].taken), $sformatf("br_cond_%0h", br_tab[i].cc));
    end

    // Halt: absorbing regardless of MemReady, left only by reset.
    Instr = 32'hC000_0000;
    cyc(1'b1, w_fetch(1'b1), "halt_fetch");
    cyc(1'b1, w_dec(), "halt_decode");
    for (int i = 0; i < 20; i++) cyc(1'($urandom_range(0, 1)), w_halt(), "halt_hold");
    rst_n = 1'b0;
    cyc(1'b1, '0, "halt_reset");
    rst_n = 1'b1;

    // Store aborted by reset during a MEM_WR wait.
    Instr = 32'h4000_0000;
    cyc(1'b1, w_fetch(1'b1), "st_fetch");
    cyc(1'b1, w_dec(), "st_decode");
    cyc(1'b1, w_madr(), "st_addr");
    cyc(1'b0, w_mwr(), "st_wr_wait");
    rst_n = 1'b0;
    cyc(1'b1, '0, "st_reset_cycle");
    rst_n = 1'b1;
    cyc(1'b0, w_fetch(1'b0), "st_after_reset");
    rst_n = 1'b0;
    cyc(1'b1, '0, "pre_random_reset");
    rst_n = 1'b1;

    // Randomized run against the step-list model.
    q.delete();
    for (int n_cyc = 0; n_cyc < 3000; n_cyc++) begin
      if (q.size() == 0) begin
        ins = $urandom;
        ins[31:30] = 2'($urandom_range(0, 2));
        Instr = ins;
        plan_instr(ins);
      end
      rdy    = ($urandom_range(0, 3) != 0);
      do_rst = ($urandom_range(0, 49) == 0);
      {Z, N, C, V} = 4'($urandom);
      rst_n = !do_rst;
      hd = q[0];
      if (do_rst)                   exp = '0;
      else if (hd.kind == K_FIXED)  exp = hd.wa;
      else if (hd.kind == K_MEM)    exp = rdy ? hd.wb : hd.wa;
      else                          exp = w_br(ref_taken(hd.cc, Z, N, C, V));
      cyc(rdy, exp, "random");
      if (do_rst)                           q.delete();
      else if (!(hd.kind == K_MEM && !rdy)) void'(q.pop_front());
      rst_n = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
